// File: rtl/rv_muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide execute unit.
package rv_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one step per cycle.
module muldiv_core
  import rv_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi_c,
  output logic [XLEN-1:0] lo_c,
  output logic            last_c
);

  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    sum, shl, diff;

  // Post-step accumulator: hi is the running upper product / partial remainder.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shl  = {hi_q, lo_q[XLEN-1]};
    diff = shl - {1'b0, m_q};
    if (div_q) begin
      hi_c = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
      lo_c = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      {hi_c, lo_c} = {sum, lo_q[XLEN-1:1]};
    end
  end

  assign last_c = (cnt_q == CNT_W'(ITER - 1));

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    m_d   = m_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      hi_d  = '0;
      lo_d  = is_div ? a_mag : b_mag;
      m_d   = is_div ? b_mag : a_mag;
      div_d = is_div;
      cnt_d = '0;
    end else if (step) begin
      hi_d  = hi_c;
      lo_d  = lo_c;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// RV32M multi-cycle execute unit: control FSM, sign handling and special cases around muldiv_core.
module rv32m_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  write_back_en
);

  muldiv_state_e         state_q, state_d;
  muldiv_op_e            op_q, op_d, op_in;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d, wr_addr_q, wr_addr_d;
  logic                  neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  busy_q, busy_d, done_q, done_d, wbe_q, wbe_d;

  logic                  a_sgn, b_sgn, is_div, is_rem, div_zero, ovf, fast;
  logic [XLEN-1:0]       a_mag, b_mag, fast_res;
  logic                  core_load, core_step, core_last_c;
  logic [XLEN-1:0]       core_hi_c, core_lo_c;
  logic [2*XLEN-1:0]     prod_raw, prod;
  logic [XLEN-1:0]       quot, rem, final_res;

  // Operand decode, valid while the request is being accepted.
  always_comb begin
    op_in    = muldiv_op_e'(funct3);
    is_div   = funct3[2];
    is_rem   = funct3[2] & funct3[1];
    a_sgn    = !(op_in == OP_MULHU || op_in == OP_DIVU || op_in == OP_REMU) && rs1_data[XLEN-1];
    b_sgn    = (op_in == OP_MUL || op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM)
               && rs2_data[XLEN-1];
    a_mag    = a_sgn ? -rs1_data : rs1_data;
    b_mag    = b_sgn ? -rs2_data : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    ovf      = (op_in == OP_DIV || op_in == OP_REM) && (rs1_data == INT_MIN) && (rs2_data == '1);
    fast     = div_zero || ovf;
    if (div_zero) fast_res = is_rem ? rs1_data : DIV_ZERO_Q;
    else          fast_res = is_rem ? '0 : INT_MIN;
  end

  muldiv_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .step   (core_step),
    .is_div (is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi_c   (core_hi_c),
    .lo_c   (core_lo_c),
    .last_c (core_last_c)
  );

  // Final result from the last iteration's accumulator, with sign fix-up.
  always_comb begin
    prod_raw = {core_hi_c, core_lo_c};
    prod     = neg_q ? -prod_raw : prod_raw;
    quot     = neg_q ? -core_lo_c : core_lo_c;
    rem      = rneg_q ? -core_hi_c : core_hi_c;
    case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quot;
      default:                      final_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = fast ? ST_DONE : ST_RUN;
      ST_RUN:  if (core_last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    rd_d      = rd_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    wr_addr_d = wr_addr_q;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    wbe_d     = 1'b0;
    core_load = 1'b0;
    core_step = (state_q == ST_RUN);
    if (state_q == ST_IDLE && start) begin
      op_d      = op_in;
      rd_d      = rd_addr;
      neg_d     = a_sgn ^ b_sgn;
      rneg_d    = a_sgn;
      core_load = !fast;
      if (fast) begin
        result_d  = fast_res;
        wr_addr_d = rd_addr;
        wbe_d     = (rd_addr != '0);
      end
    end
    if (state_q == ST_RUN && core_last_c) begin
      result_d  = final_res;
      wr_addr_d = rd_q;
      wbe_d     = (rd_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_MUL;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wbe_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wbe_q     <= wbe_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign wr_addr       = wr_addr_q;
  assign write_back_en = wbe_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: random and directed ops against a 64-bit arithmetic model.
module tb_rv32m_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, done, write_back_en;
  logic [31:0] result;
  logic [4:0]  wr_addr;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        web;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  rv32m_muldiv_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .funct3        (funct3),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rd_addr       (rd_addr),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .wr_addr       (wr_addr),
    .write_back_en (write_back_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000:  begin p = sa * sb; return p[31:0]; end
      3'b001:  begin p = sa * sb; return p[63:32]; end
      3'b010:  begin p = sa * ub; return p[63:32]; end
      3'b011:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("wr_addr", 64'(wr_addr), 64'(e.rd));
          check("write_back_en", 64'(write_back_en), 64'(e.web));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check("wbe_without_done", 64'(write_back_en), 64'(0));
      end
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit noisy);
    exp_t e;
    int   n;
    bit   fast;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", 64'(busy), 64'(0));
    fast = (f[2] && b == 0) ||
           ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd;
    e.res = ref_model(f, a, b);
    e.rd  = rd;
    e.web = (rd != 0);
    e.cyc = cyc + (fast ? 1 : 33);
    exp_q.push_back(e);
    @(negedge clk);
    n = 0;
    start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (noisy && n < 20) begin
        start = 1'b1; funct3 = 3'($urandom);
        rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 64'(n), 64'(fast ? 1 : 33));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_wbe", 64'(write_back_en), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    do_op(3'b101, 32'd100, 32'd7, 5'd7, 1'b0);
    do_op(3'b111, 32'd100, 32'd7, 5'd8, 1'b0);
    do_op(3'b100, 32'd5, 32'd0, 5'd9, 1'b0);
    do_op(3'b111, 32'd5, 32'd0, 5'd10, 1'b0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    do_op(3'b000, 32'd1234, 32'd5678, 5'd13, 1'b1);
    do_op(3'b101, 32'hDEAD_BEEF, 32'd3, 5'd0, 1'b0);
    do_op(3'b100, 32'd5, 32'd0, 5'd0, 1'b1);

    // Abandon a divide with reset in its tenth cycle.
    while (busy !== 1'b0) @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd14;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_wbe", 64'(write_back_en), 64'(0));
    repeat (30) @(negedge clk);
    do_op(3'b000, 32'd3, 32'd4, 5'd15, 1'b0);

    for (int i = 0; i < 50; i++) begin
      do_op(3'($urandom), pick(), pick(), 5'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv_unit.md
Name: rv32m_muldiv_unit

Overview:
Multi-cycle RV32M multiply/divide execute unit. It sits directly downstream of the register file: it consumes the two read operands and the decoded funct3/rd fields, then produces the write-back data, address and enable that feed the register file write port. While busy it signals the control path to stall the single-cycle core.

Parameters:
DATA_WIDTH, 32, operand/result width (only 32 is supported)
ADDR_WIDTH, 5, register address width

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  DATA_WIDTH  operand A (dividend / multiplicand)
rs2_data  input  DATA_WIDTH  operand B (divisor / multiplier)
rd_addr  input  ADDR_WIDTH  destination register
busy  output  1  high from the cycle after an accepted start through the DONE cycle
done  output  1  one-cycle completion pulse
result  output  DATA_WIDTH  registered result
wr_addr  output  ADDR_WIDTH  registered rd for write-back
write_back_en  output  1  register file write enable

Behaviour:
- Reset: state=IDLE; busy, done, write_back_en=0; result, wr_addr=0. Reset applies mid-operation: the op is abandoned and nothing is written back.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches funct3, rd_addr and operand magnitudes/signs, then goes to RUN with iteration counter=0. Fast path goes straight to DONE when (a) the op is a divide with rs2_data=0, or (b) the op is DIV/REM with rs1_data=0x80000000 and rs2_data=0xFFFFFFFF.
- RUN: one iteration per cycle, 32 iterations, then DONE. Start in cycle 0 gives done in cycle 33; fast path gives done in cycle 1.
- Multiply: unsigned shift-add on magnitudes into a 64-bit accumulator. Signedness: MUL/MULH treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU treats both as unsigned. The product is negated if the signs differ. MUL returns bits[31:0]; MULH/MULHSU/MULHU return bits[63:32].
- Divide: restoring division on magnitudes, 32 iterations. DIV/REM are signed; DIVU/REMU are unsigned. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
- Divide by zero: quotient=0xFFFFFFFF; remainder=dividend (unmodified).
- Overflow (-2^31 / -1): quotient=0x80000000; remainder=0.
- DONE (one cycle): done=1; result and wr_addr are valid; write_back_en=1 unless wr_addr=0, in which case it stays 0. Next state is IDLE.
- result/wr_addr hold their value until the next DONE or reset.
- start while busy is ignored. A start in the DONE cycle is ignored; a new start is accepted in IDLE the following cycle.
- Operands are only sampled at acceptance; later input changes have no effect.

Decomposition:
- Package rv_muldiv_pkg holds:
  - muldiv_op_e: funct3 enum, 3 bits
  - muldiv_state_e: IDLE/RUN/DONE
  - constants XLEN=32, ITER=32, DIV_ZERO_Q=32'hFFFF_FFFF, INT_MIN=32'h8000_0000
- Sub-module muldiv_core: the iterative shift-add/restoring datapath (accumulator, counter, step enable). Control FSM, sign handling and special cases stay in the top.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> cycle 33: result=0xFFFFFFEB, wr_addr=5, done and write_back_en high for exactly 1 cycle; busy high cycles 1-33.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100,7 -> 2.
4. Fast path, each with done in cycle 1:
   - DIV 5/0 -> 0xFFFFFFFF
   - REMU 5,0 -> 5
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
   - REM same operands -> 0
5. start pulses during RUN with different operands -> ignored, original result returned. Op with rd=0 -> done pulses, write_back_en stays 0.
6. rst in cycle 10 of a DIV -> cycle 11: busy=0, result=0, no done/write_back_en ever. Next MUL 3x4 -> 12 in cycle 33 after its start.
